instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the program-memory ROM. Owns the program counter and drives the ROM address.
- Captures the combinational instruction the ROM returns, together with its PC, into a small FIFO. Presents entries to decode over a valid/ready handshake.
- Handles control-flow redirects by flushing the FIFO. Keeps a fetched-instruction counter for debug.

Parameters:
- RESET_PC, 32'h0040_0000, PC value loaded on reset.
- DATA_WIDTH, 32, width of PC and instruction.
- FIFO_DEPTH, 2, number of buffered fetch entries; power of two, at least 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_o  output  DATA_WIDTH  current PC; drives the ROM address input.
- instr_i  input  DATA_WIDTH  ROM data for pc_o; valid in the same cycle (combinational ROM).
- redirect_i  input  1  branch/jump taken; flush and reload PC.
- redirect_pc_i  input  DATA_WIDTH  redirect target.
- out_valid_o  output  1  FIFO head holds a valid entry.
- out_instr_o  output  DATA_WIDTH  head instruction.
- out_pc_o  output  DATA_WIDTH  PC of head instruction.
- out_ready_i  input  1  decode accepts head this cycle.
- misalign_o  output  1  sticky flag: a redirect target had bits [1:0] != 0.
- fetch_count_o  output  32  number of instructions pushed since reset; wraps.

Behaviour:
- Reset (asynchronous assert, synchronous-safe release):
  - pc_o = RESET_PC.
  - FIFO empty: out_valid_o = 0; out_instr_o and out_pc_o = 0.
  - misalign_o = 0, fetch_count_o = 0.
- Definitions:
  - pop = out_valid_o & out_ready_i.
  - push = !redirect_i & (count < FIFO_DEPTH | pop).
- Push, on the rising edge:
  - Write {pc_o, instr_i} at the tail; pc_o <= pc_o + 4 (mod 2^DATA_WIDTH).
  - fetch_count_o increments by 1.
  - Fetch latency: an instruction appears on out_* one cycle after its PC is on pc_o.
- Stall: with no push and no redirect, pc_o holds. The ROM is re-read; no side effects.
- Pop: head advances; count decrements unless a push happens in the same cycle.
  - Full FIFO with simultaneous push and pop: count unchanged, both pointers advance.
- Redirect (redirect_i = 1), which has priority over push and pop:
  - All FIFO entries are discarded; count = 0 and out_valid_o = 0 next cycle.
  - pc_o <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00}.
  - If redirect_pc_i[1:0] != 0, misalign_o <= 1; it stays set until reset.
  - No push that cycle, and fetch_count_o does not increment.
  - A pop handshake in the same cycle is still considered consumed by decode; the entry is gone either way.
- Output timing:
  - out_* are registered FIFO head values and must not combinationally depend on out_ready_i.
  - Head data must stay stable while out_valid_o = 1 and out_ready_i = 0.
- Pointers: log2(FIFO_DEPTH) bits, wrap naturally. Count: log2(FIFO_DEPTH)+1 bits.
- Wrap-around: PC 32'hFFFF_FFFC + 4 yields 0. fetch_count_o wraps at 2^32.
- Reset mid-operation (asserted at any time): immediate return to reset values; in-flight entries are lost.
- Steady state: with out_ready_i tied high, throughput is one instruction per cycle.

Test Plan:
- Reset release with out_ready_i = 1 and the ROM holding word i at index i:
  - pc_o sequence 0x00400000, 0x00400004, ...
  - out_pc_o/out_instr_o follow one cycle later; out_valid_o stays high.
  - fetch_count_o = 8 after 8 cycles.
- Backpressure: out_ready_i = 0 for 5 cycles after reset:
  - FIFO fills to 2 entries; pc_o stalls at 0x00400008.
  - Head stays 0x00400000 and stable; fetch_count_o = 2.
  - On release, entries emerge in order with no loss or duplication.
- Redirect to 0x00400100 while FIFO is full:
  - Next cycle out_valid_o = 0 and pc_o = 0x00400100.
  - The cycle after, out_pc_o = 0x00400100; no stale entries appear.
- Redirect to 0x00400102: pc_o = 0x00400100 and misalign_o = 1; it stays 1 across later normal redirects.
- Full FIFO with pop and push in the same cycle: count stays 2; order is preserved across 4 such cycles.
- Reset asserted mid-stream with FIFO non-empty:
  - Outputs immediately go to reset values: pc_o = 0x00400000, out_valid_o = 0, fetch_count_o = 0.
  - Normal fetch resumes after release.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - program counter, ROM fetch capture FIFO and decode handshake
module instr_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0040_0000,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] pc_o,
    input  logic [DATA_WIDTH-1:0] instr_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic                  out_valid_o,
    output logic [DATA_WIDTH-1:0] out_instr_o,
    output logic [DATA_WIDTH-1:0] out_pc_o,
    input  logic                  out_ready_i,
    output logic                  misalign_o,
    output logic [31:0]           fetch_count_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_pc    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_instr [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [DATA_WIDTH-1:0] pc_q;
    logic                  misalign_q;
    logic [31:0]           fetch_count_q;

    logic pop;
    logic push;
    logic full;

    assign full = (count == DEPTH_C);
    assign pop  = out_valid_o & out_ready_i;
    // A full FIFO can still accept the new fetch when the head leaves this cycle.
    assign push = ~redirect_i & (~full | pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_pc[i]    <= '0;
                mem_instr[i] <= '0;
            end
        end else if (push) begin
            mem_pc[wr_ptr]    <= pc_q;
            mem_instr[wr_ptr] <= instr_i;
        end
    end

    // Redirect wins over both push and pop: pointers and count collapse to empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (redirect_i) begin
            pc_q <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
        end else if (push) begin
            pc_q <= pc_q + DATA_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            misalign_q <= 1'b0;
        end else if (redirect_i && (redirect_pc_i[1:0] != 2'b00)) begin
            misalign_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count_q <= '0;
        end else if (push) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    // Head is read straight from storage flops, so out_* never see out_ready_i.
    assign pc_o          = pc_q;
    assign out_valid_o   = (count != '0);
    assign out_pc_o      = mem_pc[rd_ptr];
    assign out_instr_o   = mem_instr[rd_ptr];
    assign misalign_o    = misalign_q;
    assign fetch_count_o = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc_o;
    logic [31:0] instr_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        out_valid_o;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic        out_ready_i;
    logic        misalign_o;
    logic [31:0] fetch_count_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    instr_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pc_o          (pc_o),
        .instr_i       (instr_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .out_valid_o   (out_valid_o),
        .out_instr_o   (out_instr_o),
        .out_pc_o      (out_pc_o),
        .out_ready_i   (out_ready_i),
        .misalign_o    (misalign_o),
        .fetch_count_o (fetch_count_o)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a >> 2) ^ 32'h5A00_0000;
    endfunction

    assign instr_i = rom(pc_o);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted head entry must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop actual_pc=%h expected=none", out_pc_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc", out_pc_o, e);
                check("sb_instr", out_instr_o, rom(e));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(start + 32'(4 * i));
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            step();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset         = 1'b0;
        out_ready_i   = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        step();
        step();
        check("rst_pc", pc_o, 32'h0040_0000);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_instr", out_instr_o, 32'h0);
        check("rst_out_pc", out_pc_o, 32'h0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        check("rst_count", fetch_count_o, 32'd0);
        reset = 1'b1;

        // Streaming with decode always ready
        push_seq(32'h0040_0000, 8);
        repeat (8) step();
        check("stream_count", fetch_count_o, 32'd8);
        check("stream_pc", pc_o, 32'h0040_0020);
        check("stream_valid", 32'(out_valid_o), 32'd1);
        step();

        // Reset asserted mid-stream with an entry buffered
        reset       = 1'b0;
        out_ready_i = 1'b0;
        #1;
        check("midrst_pc", pc_o, 32'h0040_0000);
        check("midrst_valid", 32'(out_valid_o), 32'd0);
        check("midrst_count", fetch_count_o, 32'd0);
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        step();
        step();
        reset = 1'b1;

        // Backpressure: fill and hold
        step();
        check("bp_valid", 32'(out_valid_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_head_pc", out_pc_o, 32'h0040_0000);
            check("bp_head_instr", out_instr_o, rom(32'h0040_0000));
        end
        check("bp_pc_stall", pc_o, 32'h0040_0008);
        check("bp_count", fetch_count_o, 32'd2);

        // Release: full FIFO with simultaneous push and pop
        push_seq(32'h0040_0000, 5);
        out_ready_i = 1'b1;
        repeat (4) step();
        check("pp_count", fetch_count_o, 32'd6);
        check("pp_pc", pc_o, 32'h0040_0018);
        check("pp_valid", 32'(out_valid_o), 32'd1);

        // Redirect while full, pop in the same cycle is consumed
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0100;
        step();
        redirect_i = 1'b0;
        check("redir_valid", 32'(out_valid_o), 32'd0);
        check("redir_pc", pc_o, 32'h0040_0100);
        check("redir_count", fetch_count_o, 32'd6);
        check("redir_sb_left", 32'(exp_q.size()), 32'd0);
        push_seq(32'h0040_0100, 2);
        step();
        check("redir_head_pc", out_pc_o, 32'h0040_0100);
        check("redir_head_valid", 32'(out_valid_o), 32'd1);
        step();

        // Misaligned redirect, then a normal one
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0040_0102;
        step();
        check("mis_pc", pc_o, 32'h0040_0100);
        check("mis_flag", 32'(misalign_o), 32'd1);
        redirect_pc_i = 32'h0040_0200;
        step();
        check("mis2_pc", pc_o, 32'h0040_0200);
        check("mis_sticky", 32'(misalign_o), 32'd1);
        redirect_i = 1'b0;
        push_seq(32'h0040_0200, 2);
        wait_drain();

        // PC wrap-around
        out_ready_i   = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        step();
        redirect_i  = 1'b0;
        out_ready_i = 1'b1;
        push_seq(32'hFFFF_FFF8, 4);
        step();
        step();
        check("wrap_pc", pc_o, 32'h0000_0000);
        wait_drain();
        out_ready_i = 1'b0;
        check("wrap_misalign", 32'(misalign_o), 32'd1);

        // Reset clears the sticky flag, then fetch resumes
        reset = 1'b0;
        #1;
        check("rst2_misalign", 32'(misalign_o), 32'd0);
        check("rst2_pc", pc_o, 32'h0040_0000);
        check("rst2_valid", 32'(out_valid_o), 32'd0);
        step();
        reset       = 1'b1;
        out_ready_i = 1'b1;
        push_seq(32'h0040_0000, 3);
        wait_drain();
        check("resume_count", fetch_count_o, 32'd4);
        check("resume_pc", pc_o, 32'h0040_0010);
        out_ready_i = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
